// File: rtl/xor_parity_pkg.sv
// Shared definitions for the XOR parity link: checker FSM states, parity
// sense constants and a word parity helper shared with the generator.
package xor_parity_pkg;

   typedef enum logic [1:0] {
      RECV   = 2'd0,
      PAR    = 2'd1,
      REPORT = 2'd2
   } state_t;

   localparam int unsigned PARITY_EVEN = 0;
   localparam int unsigned PARITY_ODD  = 1;

   // XOR-reduce of a word; callers zero-extend narrower words.
   function automatic logic parity_of(input logic [31:0] word);
      return ^word;
   endfunction

endpackage

// File: rtl/xor_parity_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] cnt
);

   logic [W-1:0] r_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if (clr) begin
         r_cnt <= '0;
      end else if (inc && (r_cnt != '1)) begin
         r_cnt <= r_cnt + W'(1);
      end
   end

   assign cnt = r_cnt;

endmodule

// File: rtl/xor_parity_checker.sv
// Serial XOR parity checker: deserialises DATA_BITS data bits plus a parity
// bit, flags mismatches and reports each word over a valid/ready handshake.
module xor_parity_checker
   import xor_parity_pkg::*;
#(
   parameter int          DATA_BITS  = 8,
   parameter int unsigned ODD_PARITY = PARITY_EVEN,
   parameter int          CNT_W      = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 clear,
   input  logic                 in_valid,
   input  logic                 in_bit,
   output logic                 in_ready,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [DATA_BITS-1:0] out_data,
   output logic                 out_parity_err,
   output logic [CNT_W-1:0]     frame_count,
   output logic [CNT_W-1:0]     error_count
);

   localparam int              IDX_W    = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);
   localparam logic            ODD      = (ODD_PARITY != 0) ? 1'b1 : 1'b0;

   state_t                 r_state;
   state_t                 w_next;
   logic [IDX_W-1:0]       r_idx;
   logic                   r_acc;
   logic [DATA_BITS-1:0]   r_data;
   logic                   r_out_valid;
   logic [DATA_BITS-1:0]   r_out_data;
   logic                   r_out_err;

   logic                   w_in_ready;
   logic                   w_take;
   logic                   w_err;
   logic                   w_frame_done;

   // Ready depends on state only, so there is no in_valid -> in_ready path.
   assign w_in_ready   = (r_state != REPORT);
   assign w_take       = in_valid && w_in_ready && !clear;
   assign w_err        = ((r_acc ^ in_bit) != ODD);
   assign w_frame_done = w_take && (r_state == PAR);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= RECV;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         RECV:    if (w_take && (r_idx == LAST_IDX)) w_next = PAR;
         PAR:     if (w_take)                        w_next = REPORT;
         REPORT:  if (r_out_valid && out_ready)      w_next = RECV;
         default: w_next = RECV;
      endcase
      if (clear) w_next = RECV;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_idx       <= '0;
         r_acc       <= 1'b0;
         r_data      <= '0;
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
         r_out_err   <= 1'b0;
      end else if (clear) begin
         r_idx       <= '0;
         r_acc       <= 1'b0;
         r_out_valid <= 1'b0;
      end else begin
         case (r_state)
            RECV: if (w_take) begin
               r_data[r_idx] <= in_bit;
               r_acc         <= r_acc ^ in_bit;
               r_idx         <= (r_idx == LAST_IDX) ? '0 : r_idx + IDX_W'(1);
            end
            PAR: if (w_take) begin
               r_out_data  <= r_data;
               r_out_err   <= w_err;
               r_out_valid <= 1'b1;
            end
            REPORT: if (r_out_valid && out_ready) begin
               r_out_valid <= 1'b0;
               r_acc       <= 1'b0;
            end
            default: ;
         endcase
      end
   end

   sat_counter #(.W(CNT_W)) u_frame_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (clear),
      .inc   (w_frame_done),
      .cnt   (frame_count)
   );

   sat_counter #(.W(CNT_W)) u_error_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (clear),
      .inc   (w_frame_done && w_err),
      .cnt   (error_count)
   );

   assign in_ready       = w_in_ready;
   assign out_valid      = r_out_valid;
   assign out_data       = r_out_data;
   assign out_parity_err = r_out_err;

endmodule

// File: doc/xor_parity_checker.md
Name: xor_parity_checker

Overview:
- Serial receive-side checker for the team's XOR-based parity protocol. It is the decode end of the parity generator built on xor_1b.
- It deserialises a bit stream of DATA_BITS data bits followed by one parity bit. It recomputes parity with a running XOR and presents each decoded word with an error flag over a valid/ready handshake.
- It keeps saturating frame and error counters for link monitoring.

Parameters:
- DATA_BITS, 8, data bits per frame; range 1..32; the parity bit is not included.
- ODD_PARITY, 0, 0 = even parity (XOR of data and parity bits = 0); 1 = odd parity (XOR = 1).
- CNT_W, 16, width of frame_count and error_count.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- clear  input  1  synchronous clear of counters and of any partial frame.
- in_valid  input  1  in_bit is valid this cycle.
- in_bit  input  1  serial bit, LSB of data first, parity bit last.
- in_ready  output  1  checker can accept a bit.
- out_valid  output  1  decoded frame available.
- out_ready  input  1  downstream accepts the frame.
- out_data  output  DATA_BITS  decoded data word.
- out_parity_err  output  1  parity mismatch for out_data.
- frame_count  output  CNT_W  frames completed, saturating.
- error_count  output  CNT_W  frames with a parity error, saturating.

Behaviour:
- Reset (rst_n low, asynchronous): state = RECV, bit index = 0, XOR accumulator = 0, out_valid = 0, out_data = 0, out_parity_err = 0, both counters = 0. in_ready = 1 once out of reset.
- A bit is accepted when in_valid && in_ready at a rising clk edge. Idle cycles (in_valid = 0) are allowed anywhere in a frame and change no state.
- FSM states: RECV, PAR, REPORT.
- RECV:
  - in_ready = 1.
  - Each accepted bit is written to data position idx, acc ^= bit, idx++.
  - When the accepted bit is at idx = DATA_BITS-1: go to PAR and set idx = 0.
- PAR:
  - in_ready = 1.
  - An accepted bit is the parity bit. Compute err = (acc ^ bit) != ODD_PARITY.
  - Load out_data and out_parity_err, set out_valid = 1, then go to REPORT.
  - frame_count++ and, if err, error_count++, both on the same edge.
  - Counters saturate at 2^CNT_W-1 and never wrap.
- REPORT:
  - in_ready = 0; in_bit is ignored.
  - out_valid, out_data and out_parity_err are held stable until out_valid && out_ready.
  - On that edge: out_valid = 0, acc = 0, go to RECV.
  - out_data and out_parity_err keep their last values after the handshake.
- Latency: out_valid rises on the clock edge that accepts the parity bit and is visible the following cycle. Minimum frame period is DATA_BITS+2 cycles when out_ready is held at 1.
- clear takes priority over all other inputs:
  - Zero both counters and abort any partial frame: acc = 0, idx = 0, state = RECV.
  - out_valid = 0, so a pending REPORT frame is discarded.
  - An in_valid bit in the same cycle as clear is dropped.
- Reset mid-frame: the partial frame is lost. The first bit accepted after reset is data bit 0 of a new frame.
- in_ready is a combinational decode of state only, with no input-to-output path. out_valid is registered.

Decomposition:
- Shared package xor_parity_pkg holds:
  - the state enum (RECV, PAR, REPORT);
  - PARITY_EVEN = 0 and PARITY_ODD = 1 constants;
  - a parity_of(word) function, also used by the future generator.
- Natural sub-module: sat_counter (width CNT_W, inc, clr, saturating). It is instantiated twice, for frame_count and error_count.

Test Plan:
All scenarios use DATA_BITS=8 and ODD_PARITY=0 unless stated otherwise.
1. Send 0xA5 as bits 1,0,1,0,0,1,0,1 then parity 0, out_ready = 1 -> out_valid for 1 cycle, out_data = 0xA5, out_parity_err = 0, frame_count = 1, error_count = 0.
2. Send 0x07 with parity 0 (correct parity is 1) -> out_data = 0x07, out_parity_err = 1, error_count = 1. Then 0x07 with parity 1 -> err = 0, frame_count = 2. Repeat with ODD_PARITY=1 -> the flags invert.
3. Backpressure: hold out_ready = 0 for 5 cycles after a frame while in_valid = 1 -> in_ready = 0 and out_data stable throughout. No bits are consumed. The next frame decodes correctly after out_ready = 1.
4. Insert random in_valid = 0 gaps inside a frame of 0x3C -> out_data = 0x3C, err = 0, same result as the gap-free case.
5. After 4 data bits, pulse rst_n low asynchronously (mid-cycle) -> all outputs 0 immediately. A following full frame of 0xFF with parity 0 decodes to 0xFF, err = 0. Repeat with clear after 4 bits -> counters 0, out_valid 0, next frame correct.
6. CNT_W=2: send 5 frames, all with bad parity -> frame_count and error_count stop at 3 and do not wrap. Assert clear -> both return to 0.
